// File: rtl/mmio_responder.sv
// MMIO responder on the data-memory bus.
// Provides a key FIFO, a tick counter, a control register and a scratch register.
module mmio_responder #(
  parameter logic [11:0] BASE_ADDR  = 12'hF00,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TICK_DIV   = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address,
  input  logic [31:0] wdata,
  input  logic        wren,
  input  logic        rden,
  input  logic        key_strobe,
  input  logic [7:0]  key_code,
  output logic        io_sel,
  output logic        io_sel_q,
  output logic [31:0] io_q,
  output logic        key_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [3:0] OFF_STATUS  = 4'd0;
  localparam logic [3:0] OFF_KEY     = 4'd1;
  localparam logic [3:0] OFF_TICKS   = 4'd2;
  localparam logic [3:0] OFF_CTRL    = 4'd3;
  localparam logic [3:0] OFF_SCRATCH = 4'd4;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          ovf;
  logic          tick_en;
  logic [PW-1:0] presc;
  logic [31:0]   ticks;
  logic [31:0]   scratch;

  logic [3:0]  off;
  logic        wr_acc;
  logic        rd_acc;
  logic        sel_status;
  logic        sel_key;
  logic        sel_ticks;
  logic        sel_ctrl;
  logic        sel_scratch;
  logic        not_empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        drop;
  logic        tick_wrap;
  logic [31:0] status;
  logic [31:0] rdata;

  assign off    = address[3:0];
  assign io_sel = (address[11:4] == BASE_ADDR[11:4]);
  assign wr_acc = wren & io_sel;
  // A store cycle never doubles as a load, so it cannot pop.
  assign rd_acc = rden & io_sel & ~wren;

  assign sel_status  = (off == OFF_STATUS);
  assign sel_key     = (off == OFF_KEY);
  assign sel_ticks   = (off == OFF_TICKS);
  assign sel_ctrl    = (off == OFF_CTRL);
  assign sel_scratch = (off == OFF_SCRATCH);

  assign not_empty = (count != '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop       = rd_acc & sel_key & not_empty;
  assign push      = key_strobe & (~full | pop);
  assign drop      = key_strobe & full & ~pop;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign tick_wrap = tick_en & (presc == PW'(TICK_DIV - 1));

  always_comb begin
    status       = '0;
    status[0]    = not_empty;
    status[1]    = full;
    status[2]    = ovf;
    status[11:8] = 4'(count);
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_status:  rdata = status;
      sel_key:     rdata = {24'b0, not_empty ? mem[rd_ptr] : 8'h00};
      sel_ticks:   rdata = ticks;
      sel_ctrl:    rdata = {31'b0, tick_en};
      sel_scratch: rdata = scratch;
      default:     rdata = '0;
    endcase
  end

  // Storage needs no reset; the empty pointers make stale entries unreachable.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= key_code;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_q     <= '0;
      io_sel_q <= 1'b0;
      key_irq  <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      tick_en  <= 1'b0;
      presc    <= '0;
      ticks    <= '0;
      scratch  <= '0;
    end else begin
      io_q     <= rd_acc ? rdata : '0;
      io_sel_q <= io_sel;
      key_irq  <= (count_nxt != '0);
      count    <= count_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (drop)                            ovf <= 1'b1;
      else if (wr_acc & sel_ctrl & wdata[1]) ovf <= 1'b0;

      if (wr_acc & sel_ctrl)    tick_en <= wdata[0];
      if (wr_acc & sel_scratch) scratch <= wdata;

      if (tick_en) presc <= tick_wrap ? '0 : presc + 1'b1;

      if (wr_acc & sel_ticks) ticks <= wdata;
      else if (tick_wrap)     ticks <= ticks + 32'd1;
    end
  end

endmodule
